i2s_tx: RTL and testbench

//  Sink for the 24-bit valid/ready sample stream produced by the tone/sample sources.
//  - Consumes one mono sample per audio frame.
//  - Serialises it MSB-first onto a standard I2S link (bclk, lrclk, sdata) toward the codec.
//  - The same sample is sent on both the left and right channels.
//  - Sits between the sample source and the codec pins. bclk/lrclk are generated from clk.

---
 rtl/i2s_tx_if.sv | 21 ++
 rtl/i2s_tx.sv | 145 ++++++++++++++
 tb/tb_i2s_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: valid/ready sample stream carrying one signed mono sample per
// transfer from a sample source (master) to the I2S transmitter (slave).
interface i2s_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: sink for a signed valid/ready sample stream. Each accepted mono
// sample is serialised MSB-first onto a standard I2S link (bclk, lrclk,
// sdata) and sent identically on the left and right channels. bclk and
// lrclk are derived from clk. A frame that starts with no sample held is
// sent as zeros and flagged with a one-cycle underrun pulse.
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to add a saturating
// 16-bit underrun_count output.
module i2s_tx #(
    parameter int CLK_DIV    = 2,
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    i2s_tx_if.slave     src,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_count
`endif
);
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_POS = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] DATA_POS = BIT_W'(DATA_WIDTH);

    logic [DIV_W-1:0]             div_cnt;
    logic [BIT_W-1:0]             bit_cnt;
    logic [BIT_W-1:0]             bit_next;
    logic [BIT_W-1:0]             slot_pos;
    logic signed [DATA_WIDTH-1:0] holding;
    logic signed [DATA_WIDTH-1:0] frame;
    logic signed [DATA_WIDTH-1:0] frame_next;
    logic                         full;
    logic                         full_next;
    logic                         div_wrap;
    logic                         fall;
    logic                         frame_start;
    logic                         accept;

    // Bit of the frame word driven at slot position pos: MSB at pos 1
    // (one-bclk I2S delay), zero at pos 0 and past the last data bit.
    function automatic logic serial_bit(input logic signed [DATA_WIDTH-1:0] word,
                                        input logic [BIT_W-1:0] pos);
        logic [DATA_WIDTH-1:0] shifted;
        shifted    = word << (pos - BIT_W'(1));
        serial_bit = 1'b0;
        if (pos != '0 && pos <= DATA_POS) begin
            serial_bit = shifted[DATA_WIDTH-1];
        end
    endfunction

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        sat_inc = (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction
`endif

    // Timing events, next bit position and the frame/holding hand-over.
    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        fall        = div_wrap && bclk;
        frame_start = fall && (bit_cnt == BIT_LAST);
        bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        slot_pos    = (bit_next >= SLOT_POS) ? bit_next - SLOT_POS : bit_next;
        accept      = src.in_valid && src.in_ready;
        frame_next  = frame;
        full_next   = full;
        if (frame_start) begin
            frame_next = full ? holding : '0;
            full_next  = 1'b0;
        end
        // Holding is never full when in_ready is high, so an accept can
        // only refill an empty (or just-emptied) holding register.
        if (accept) begin
            full_next = 1'b1;
        end
    end

    // Clock divider: toggle bclk every CLK_DIV clk cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Serialiser: on each bclk falling edge advance the bit position and
    // update word select and data so both are stable at the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= BIT_LAST;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
            frame   <= '0;
        end else if (fall) begin
            bit_cnt <= bit_next;
            lrclk   <= (bit_next >= SLOT_POS);
            sdata   <= serial_bit(frame_next, slot_pos);
            frame   <= frame_next;
        end
    end

    // Input handshake: single-entry holding register, ready while empty;
    // underrun flags a frame that had to start with nothing held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holding      <= '0;
            full         <= 1'b0;
            src.in_ready <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (accept) begin
                holding <= src.in_data;
            end
            full         <= full_next;
            src.in_ready <= ~full_next;
            underrun     <= frame_start && !full;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses, one cycle behind the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (underrun) begin
            underrun_count <= sat_inc(underrun_count);
        end
    end
`endif
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed stimulus for i2s_tx with a frame scoreboard. The
// stimulus pushes the expected content of every frame (sample value and
// underrun flag); a monitor decodes the I2S link on clk falling edges and
// pops/compares one entry per completed 64-bit frame.
module tb_i2s_tx;
    localparam int DW = 24;
    localparam int SW = 32;
    localparam int FB = 2 * SW;

    typedef struct {
        logic [DW-1:0] data;
        logic          ur;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk;
    logic lrclk;
    logic sdata;
    logic underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    i2s_tx_if #(.DATA_WIDTH(DW)) bus ();

    i2s_tx #(
        .CLK_DIV   (2),
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(SW)
    ) dut (
        .clk     (clk),
        .reset   (rst),
        .src     (bus),
        .bclk    (bclk),
        .lrclk   (lrclk),
        .sdata   (sdata),
        .underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frame_no = 0;
    int   pos      = -1;

    // Monitor state
    logic bits_q[FB];
    logic lr_q[FB];
    logic prev_bclk = 1'b0;
    logic fell;
    logic ur_at_start = 1'b0;
    int   gap = 0;
    int   gap_err = 0;
    int   spur_ur = 0;
    bit   have_prev_fall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic eval_frame();
        exp_t        e;
        logic [DW-1:0] lw;
        logic [DW-1:0] rw;
        int          pad;
        int          lr_err;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: frame %0d completed with no expectation queued", frame_no);
            return;
        end
        e = sb.pop_front();
        lw = '0;
        rw = '0;
        for (int p = 1; p <= DW; p++) begin
            lw = {lw[DW-2:0], bits_q[p]};
            rw = {rw[DW-2:0], bits_q[SW + p]};
        end
        pad = 0;
        lr_err = 0;
        for (int i = 0; i < FB; i++) begin
            if ((i % SW) == 0 || (i % SW) > DW) begin
                if (bits_q[i] !== 1'b0) pad++;
            end
            if (lr_q[i] !== ((i >= SW) ? 1'b1 : 1'b0)) lr_err++;
        end
        check($sformatf("left_data_f%0d", frame_no), 32'(lw), 32'(e.data));
        check($sformatf("right_data_f%0d", frame_no), 32'(rw), 32'(e.data));
        check($sformatf("pad_zero_f%0d", frame_no), pad, 0);
        check($sformatf("lrclk_pattern_f%0d", frame_no), lr_err, 0);
        check($sformatf("underrun_flag_f%0d", frame_no), 32'(ur_at_start), 32'(e.ur));
        check($sformatf("bclk_period_f%0d", frame_no), gap_err, 0);
        check($sformatf("underrun_width_f%0d", frame_no), spur_ur, 0);
    endtask

    // Link decoder: detect bclk falls, track bit position, score frames.
    always @(negedge clk) begin
        if (rst) begin
            pos            = -1;
            prev_bclk      = 1'b0;
            gap            = 0;
            gap_err        = 0;
            spur_ur        = 0;
            have_prev_fall = 1'b0;
        end else begin
            fell      = prev_bclk && !bclk;
            prev_bclk = bclk;
            gap++;
            if (fell) begin
                if (have_prev_fall && gap != 4) gap_err++;
                have_prev_fall = 1'b1;
                gap = 0;
                pos = (pos == FB - 1 || pos < 0) ? 0 : pos + 1;
                if (pos == 0) begin
                    frame_no++;
                    ur_at_start = underrun;
                end
                bits_q[pos] = sdata;
                lr_q[pos]   = lrclk;
            end
            if (underrun && !(fell && pos == 0)) spur_ur++;
            if (fell && pos == FB - 1) begin
                eval_frame();
                gap_err = 0;
                spur_ur = 0;
            end
        end
    end

    task automatic wait_frame(input int n);
        int t;
        t = 0;
        while (frame_no < n && t < 5000) begin
            tick();
            t++;
        end
        if (frame_no < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: frame_no %0d required %0d", frame_no, n);
        end
    endtask

    // Offer one sample; optionally keep in_valid high afterwards. When
    // prev_frame >= 0, in_ready must not come back within that frame.
    task automatic send(input logic [DW-1:0] d, input bit keep_valid, input int prev_frame,
                        input bit expect_tx, output int acc_frame);
        int t;
        acc_frame   = -1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        t = 0;
        while (!bus.in_ready && t < 2000) begin
            tick();
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready 0 required 1 for data %h", d);
            bus.in_valid = 1'b0;
            return;
        end
        if (prev_frame >= 0) begin
            check("ready_low_until_frame_start", 32'(frame_no != prev_frame), 32'd1);
        end
        @(posedge clk);
        #1;
        acc_frame = frame_no;
        if (expect_tx) sb.push_back('{d, 1'b0});
        check("ready_drop_after_accept", 32'(bus.in_ready), 32'd0);
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d frames outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, ax;
        int base;
        int t;
        logic [3:0] pat;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (5) tick();
        check("reset_outputs", 32'({bclk, lrclk, sdata, bus.in_ready, underrun}), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("reset_count", 32'(underrun_count), 32'd0);
`endif

        // Reset release, ready one clk later, first fall four clks later
        sb.push_back('{24'h000000, 1'b1});
        rst = 1'b0;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) check("ready_after_release", 32'(bus.in_ready), 32'd1);
            pat = {pat[2:0], bclk};
        end
        check("bclk_first_cycles", 32'(pat), 32'h6);
        check("first_fall_underrun", 32'(underrun), 32'd1);
        check("first_frame_seen", frame_no, 1);

        // Sample path: A5A5A5 accepted in frame 1, sent in frame 2
        send(24'hA5A5A5, 1'b0, -1, 1'b1, a0);
        check("a5_accept_frame", a0, 1);

        // Underrun: three idle frames
        repeat (3) sb.push_back('{24'h000000, 1'b1});
        wait_frame(5);
        tick();
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_count_4", 32'(underrun_count), 32'd4);
`endif

        // Backpressure: in_valid held high across three samples
        send(24'h000001, 1'b1, -1, 1'b1, a1);
        send(24'h800000, 1'b1, a1, 1'b1, a2);
        send(24'h7FFFFF, 1'b0, a2, 1'b1, a3);
        check("burst_first_frame", a1, 5);
        check("one_accept_per_frame_a", a2, a1 + 1);
        check("one_accept_per_frame_b", a3, a2 + 1);
        sb.push_back('{24'h000000, 1'b1});

        // Reset mid-frame with a sample held, during the right slot
        wait_frame(9);
        send(24'h123456, 1'b0, -1, 1'b0, ax);
        t = 0;
        while (pos < SW + 8 && t < 1000) begin
            tick();
            t++;
        end
        check("pre_reset_lrclk", 32'(lrclk), 32'd1);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_reset_outputs", 32'({bclk, lrclk, sdata, bus.in_ready, underrun}), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        base = frame_no;
        sb.push_back('{24'h000000, 1'b1});
        sb.push_back('{24'h000000, 1'b1});
        wait_frame(base + 2);
        drain();
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("count_after_reset", 32'(underrun_count), 32'd2);
        // Saturation from one below full scale
        force dut.underrun_count = 16'hFFFE;
        tick();
        release dut.underrun_count;
        repeat (3) sb.push_back('{24'h000000, 1'b1});
        drain();
        repeat (2) tick();
        check("count_saturates", 32'(underrun_count), 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
